weight_programmer: RTL and testbench

Register-backed source for the `weight` buses of an N×N array of coupled oscillator cells; replaces the free-running weight wires. Accepts coupling writes over a valid/ready port, mirrors each write so J(r,c)=J(c,r), supports a bulk clear to zero coupling, and owns the array's oscillator reset (`osc_rstn`). Oscillators are held in reset whenever weights can change.

---
 rtl/ising_pkg.sv | 22 ++
 rtl/weight_programmer_if.sv | 16 +
 rtl/coupling_weight_reg.sv | 20 ++
 rtl/weight_programmer.sv | 116 +++++++++++
 tb/tb_weight_programmer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ising_pkg.sv
// Shared definitions for the oscillator array and its weight programmer.
package ising_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MIRROR = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // Weight code that gives equal match/mismatch delay, i.e. zero coupling.
  function automatic int unsigned weight_mid(input int unsigned num_weights);
    return num_weights / 2;
  endfunction

  // Flat cell offset of (r,c) in an n-by-n array, in units of one weight field.
  function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/weight_programmer_if.sv
// Valid/ready coupling-write port of the weight programmer.
interface weight_programmer_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned WB = 3
);
  localparam int unsigned IW = $clog2(N);

  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] wr_col;
  logic [WB-1:0] wr_weight;

  modport master (output wr_valid, wr_row, wr_col, wr_weight, input wr_ready);
  modport slave  (input wr_valid, wr_row, wr_col, wr_weight, output wr_ready);
endinterface

// File: rtl/coupling_weight_reg.sv
// One cell's weight register: synchronous load-to-MID, otherwise write-enabled load.
module coupling_weight_reg #(
  parameter int unsigned    WB  = 3,
  parameter logic [WB-1:0] MID = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_mid,
  input  logic          we,
  input  logic [WB-1:0] d,
  output logic [WB-1:0] q
);

  // Reset and clear both restore zero coupling; clear takes priority over a write.
  always_ff @(posedge clk) begin
    if (rst || load_mid) q <= MID;
    else if (we)         q <= d;
  end

endmodule

// File: rtl/weight_programmer.sv
// Register-backed weight source for the N x N oscillator array: symmetric
// writes, row-by-row bulk clear, and ownership of the oscillator reset.
module weight_programmer
  import ising_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned NUM_WEIGHTS = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  weight_programmer_if.slave                     wr,
  input  logic                                   clr_start,
  input  logic                                   run_start,
  input  logic                                   run_stop,
  output logic                                   busy,
  output logic                                   err,
  output logic                                   osc_rstn,
  output logic [N*N*$clog2(NUM_WEIGHTS)-1:0]     weights
);

  localparam int unsigned   WB       = $clog2(NUM_WEIGHTS);
  localparam int unsigned   IW       = $clog2(N);
  localparam logic [WB-1:0] MID      = WB'(weight_mid(NUM_WEIGHTS));
  localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);

  state_t        state, state_nx;
  logic [IW-1:0] clr_row;
  logic [IW-1:0] mir_row, mir_col;
  logic [WB-1:0] mir_w;
  logic          wr_fire, wr_good, wr_bad;
  logic [WB-1:0] cell_d;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; in IDLE clear beats run, run beats a write.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (clr_start)    state_nx = ST_CLEAR;
        else if (run_start) state_nx = ST_RUN;
        else if (wr_good) state_nx = ST_MIRROR;
      end
      ST_MIRROR: state_nx = ST_IDLE;
      ST_CLEAR:  if (clr_row == LAST_ROW) state_nx = ST_IDLE;
      ST_RUN:    if (run_stop) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State-decoded outputs and write qualification; ready depends on state only.
  always_comb begin
    wr.wr_ready = (state == ST_IDLE);
    busy        = (state == ST_MIRROR) || (state == ST_CLEAR);
    wr_fire     = (state == ST_IDLE) && wr.wr_valid && !clr_start && !run_start;
    wr_good     = wr_fire && (wr.wr_row != wr.wr_col) && (32'(wr.wr_weight) < NUM_WEIGHTS);
    wr_bad      = wr_fire && !wr_good;
    cell_d      = (state == ST_MIRROR) ? mir_w : wr.wr_weight;
  end

  // Row counter, mirror latch, sticky error and the registered oscillator reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_row  <= '0;
      mir_row  <= '0;
      mir_col  <= '0;
      mir_w    <= '0;
      err      <= 1'b0;
      osc_rstn <= 1'b0;
    end else begin
      osc_rstn <= (state_nx == ST_RUN);
      if (state == ST_IDLE && clr_start) begin
        clr_row <= '0;
        err     <= 1'b0;
      end else if (state == ST_CLEAR) begin
        clr_row <= (clr_row == LAST_ROW) ? '0 : clr_row + IW'(1);
      end
      if (wr_good) begin
        mir_row <= wr.wr_col;
        mir_col <= wr.wr_row;
        mir_w   <= wr.wr_weight;
      end
      if (wr_bad) err <= 1'b1;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int unsigned   IDX = cell_idx(r, c, N);
      localparam logic [IW-1:0] R   = IW'(r);
      localparam logic [IW-1:0] C   = IW'(c);
      logic we, clr;

      // Cell selected by the direct write in IDLE, the mirrored write, or its row's clear.
      always_comb begin
        we  = (wr_good && wr.wr_row == R && wr.wr_col == C) ||
              (state == ST_MIRROR && mir_row == R && mir_col == C);
        clr = (state == ST_CLEAR) && (clr_row == R);
      end

      coupling_weight_reg #(.WB(WB), .MID(MID)) u_reg (
        .clk      (clk),
        .rst      (rst),
        .load_mid (clr),
        .we       (we),
        .d        (cell_d),
        .q        (weights[IDX*WB +: WB])
      );
    end
  end

endmodule

// File: tb/tb_weight_programmer.sv
// Self-checking bench for weight_programmer: table-driven writes with a
// scoreboard of expected cell updates, plus clear/run/reset sequences.
module tb_weight_programmer;

  localparam int unsigned N   = 8;
  localparam int unsigned NW  = 5;
  localparam int unsigned WB  = 3;
  localparam int unsigned BW  = N * N * WB;
  localparam int unsigned MID = 2;

  logic          clk = 1'b0;
  logic          rst, clr_start, run_start, run_stop;
  logic          busy, err, osc_rstn;
  logic [BW-1:0] weights;

  weight_programmer_if #(.N(N), .WB(WB)) wif ();

  weight_programmer #(.N(N), .NUM_WEIGHTS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wif),
    .clr_start (clr_start),
    .run_start (run_start),
    .run_stop  (run_stop),
    .busy      (busy),
    .err       (err),
    .osc_rstn  (osc_rstn),
    .weights   (weights)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; int w; } sb_t;
  typedef struct { string name; int r; int c; int w; bit ok; bit err; } vec_t;

  int  checks   = 0;
  int  failures = 0;
  int  model [N][N];
  sb_t sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_bus();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        b[(r*N+c)*WB +: WB] = WB'(model[r][c]);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model[r][c] = MID;
  endtask

  task automatic pop_check(input string name);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: got empty scoreboard expected an entry", name);
    end else begin
      checks--;
      e = sb.pop_front();
      model[e.r][e.c] = e.w;
      check({name, "_cell"}, BW'(weights[(e.r*N+e.c)*WB +: WB]), BW'(e.w));
      check({name, "_bus"}, weights, model_bus());
    end
  endtask

  task automatic drive_wr(input int r, input int c, input int w);
    wif.wr_row    = 3'(r);
    wif.wr_col    = 3'(c);
    wif.wr_weight = 3'(w);
    wif.wr_valid  = 1'b1;
  endtask

  task automatic good_write(input string name, input int r, input int c, input int w);
    drive_wr(r, c, w);
    sb.push_back('{r: r, c: c, w: w});
    sb.push_back('{r: c, c: r, w: w});
    tick();
    wif.wr_valid = 1'b0;
    pop_check({name, "_direct"});
    tick();
    pop_check({name, "_mirror"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    vecs[0] = '{name: "wr_1_5_4",  r: 1, c: 5, w: 4, ok: 1'b1, err: 1'b0};
    vecs[1] = '{name: "diag_3_3",  r: 3, c: 3, w: 0, ok: 1'b0, err: 1'b1};
    vecs[2] = '{name: "badw_7",    r: 0, c: 1, w: 7, ok: 1'b0, err: 1'b1};
    vecs[3] = '{name: "wr_2_6_0",  r: 2, c: 6, w: 0, ok: 1'b1, err: 1'b1};
    vecs[4] = '{name: "badw_5",    r: 0, c: 7, w: 5, ok: 1'b0, err: 1'b1};
    vecs[5] = '{name: "wr_7_0_1",  r: 7, c: 0, w: 1, ok: 1'b1, err: 1'b1};
    vecs[6] = '{name: "wr_4_6_3",  r: 4, c: 6, w: 3, ok: 1'b1, err: 1'b1};

    rst = 1'b1; clr_start = 1'b0; run_start = 1'b0; run_stop = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_row = '0; wif.wr_col = '0; wif.wr_weight = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("rst_weights", weights, model_bus());
    check("rst_osc_rstn", BW'(osc_rstn), BW'(0));
    check("rst_ready", BW'(wif.wr_ready), BW'(1));
    check("rst_busy", BW'(busy), BW'(0));
    check("rst_err", BW'(err), BW'(0));

    // Table-driven writes, valid and invalid.
    for (int i = 0; i < 7; i++) begin
      drive_wr(vecs[i].r, vecs[i].c, vecs[i].w);
      check({vecs[i].name, "_ready_pre"}, BW'(wif.wr_ready), BW'(1));
      if (vecs[i].ok) begin
        sb.push_back('{r: vecs[i].r, c: vecs[i].c, w: vecs[i].w});
        sb.push_back('{r: vecs[i].c, c: vecs[i].r, w: vecs[i].w});
      end
      tick();
      wif.wr_valid = 1'b0;
      if (vecs[i].ok) begin
        pop_check({vecs[i].name, "_direct"});
        check({vecs[i].name, "_ready_mid"}, BW'(wif.wr_ready), BW'(0));
        check({vecs[i].name, "_busy_mid"}, BW'(busy), BW'(1));
        tick();
        pop_check({vecs[i].name, "_mirror"});
        check({vecs[i].name, "_ready_post"}, BW'(wif.wr_ready), BW'(1));
      end else begin
        check({vecs[i].name, "_nochange"}, weights, model_bus());
      end
      check({vecs[i].name, "_err"}, BW'(err), BW'(vecs[i].err));
    end

    // Clear with a write held valid throughout; write lands only after busy falls.
    drive_wr(3, 4, 1);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      check("clr_busy", BW'(busy), BW'(1));
      check("clr_ready", BW'(wif.wr_ready), BW'(0));
      tick();
      for (int c = 0; c < int'(N); c++) model[i][c] = MID;
      check("clr_row_bus", weights, model_bus());
    end
    check("clr_busy_end", BW'(busy), BW'(0));
    check("clr_ready_end", BW'(wif.wr_ready), BW'(1));
    check("clr_err_cleared", BW'(err), BW'(0));
    sb.push_back('{r: 3, c: 4, w: 1});
    sb.push_back('{r: 4, c: 3, w: 1});
    tick();
    wif.wr_valid = 1'b0;
    pop_check("held_wr_direct");
    tick();
    pop_check("held_wr_mirror");

    // Run: writes and clear ignored while oscillators are released.
    run_start = 1'b1;
    check("run_osc_pre", BW'(osc_rstn), BW'(0));
    tick();
    run_start = 1'b0;
    check("run_osc_on", BW'(osc_rstn), BW'(1));
    check("run_ready", BW'(wif.wr_ready), BW'(0));
    drive_wr(5, 2, 3);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("run_clr_ignored", BW'(busy), BW'(0));
    for (int i = 0; i < 2; i++) begin
      check("run_hold_ready", BW'(wif.wr_ready), BW'(0));
      check("run_hold_osc", BW'(osc_rstn), BW'(1));
      check("run_hold_bus", weights, model_bus());
      tick();
    end
    run_stop = 1'b1;
    wif.wr_valid = 1'b0;
    check("run_osc_before_stop", BW'(osc_rstn), BW'(1));
    tick();
    run_stop = 1'b0;
    check("stop_osc_off", BW'(osc_rstn), BW'(0));
    check("stop_ready", BW'(wif.wr_ready), BW'(1));
    check("stop_bus", weights, model_bus());

    // Clear beats run in the same cycle; reset lands in the 4th clear cycle.
    good_write("wr_6_7_0", 6, 7, 0);
    clr_start = 1'b1;
    run_start = 1'b1;
    tick();
    clr_start = 1'b0;
    run_start = 1'b0;
    check("both_busy", BW'(busy), BW'(1));
    check("both_osc", BW'(osc_rstn), BW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int c = 0; c < int'(N); c++) model[i][c] = MID;
      check("both_osc_hold", BW'(osc_rstn), BW'(0));
    end
    check("partial_clear_bus", weights, model_bus());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midclr_rst_bus", weights, model_bus());
    check("midclr_rst_busy", BW'(busy), BW'(0));
    check("midclr_rst_ready", BW'(wif.wr_ready), BW'(1));
    check("midclr_rst_err", BW'(err), BW'(0));

    // Reset during RUN and during MIRROR.
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("run2_osc_on", BW'(osc_rstn), BW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("runrst_osc", BW'(osc_rstn), BW'(0));
    check("runrst_ready", BW'(wif.wr_ready), BW'(1));
    drive_wr(2, 3, 4);
    tick();
    wif.wr_valid = 1'b0;
    model[2][3] = 4;
    check("mirrst_direct", weights, model_bus());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("mirrst_bus", weights, model_bus());
    check("mirrst_busy", BW'(busy), BW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
